// File: rtl/crossy_pkg.sv
// Shared definitions for the score sequencer and the score banner renderer:
// state encodings, score width and the BCD digit ceiling.
package crossy_pkg;

  localparam int unsigned SCORE_W = 7;
  localparam int unsigned DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_DEAD = 2'b10
  } state_t;

endpackage

// File: rtl/score_ctrl_if.sv
// Control/status bundle between the game logic and score_ctrl.
//   i_frame_tick, i_move, i_collision, i_restart : game events into score_ctrl
//   o_score, o_tens, o_ones, o_high_score        : committed and best score
//   o_state, o_digit_en                          : game state and digit visibility
// master = game/renderer side, slave = score_ctrl.
interface score_ctrl_if;
  import crossy_pkg::*;

  logic               i_frame_tick;
  logic               i_move;
  logic               i_collision;
  logic               i_restart;
  logic [SCORE_W-1:0] o_score;
  logic [DIGIT_W-1:0] o_tens;
  logic [DIGIT_W-1:0] o_ones;
  logic [SCORE_W-1:0] o_high_score;
  logic [1:0]         o_state;
  logic               o_digit_en;

  modport master (
    output i_frame_tick, i_move, i_collision, i_restart,
    input  o_score, o_tens, o_ones, o_high_score, o_state, o_digit_en
  );

  modport slave (
    input  i_frame_tick, i_move, i_collision, i_restart,
    output o_score, o_tens, o_ones, o_high_score, o_state, o_digit_en
  );

endinterface

// File: rtl/bcd2_counter.sv
// Two-digit saturating BCD up-counter with a binary shadow of the same value.
//   i_clk, i_rst : clock, async active-high reset
//   i_clr        : synchronous clear to 00 (wins over i_inc)
//   i_inc        : count up by one unless the value has reached i_limit
//   i_limit      : saturation value (binary, <= 99)
//   o_tens/o_ones: BCD digits; o_value: same value in binary
module bcd2_counter
  import crossy_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clr,
  input  logic               i_inc,
  input  logic [SCORE_W-1:0] i_limit,
  output logic [DIGIT_W-1:0] o_tens,
  output logic [DIGIT_W-1:0] o_ones,
  output logic [SCORE_W-1:0] o_value
);

  logic [DIGIT_W-1:0] r_tens;
  logic [DIGIT_W-1:0] r_ones;
  logic [SCORE_W-1:0] r_value;
  logic               w_step;

  // Binary shadow provides the saturation compare without decoding the digits.
  assign w_step = i_inc && (r_value < i_limit);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tens  <= '0;
      r_ones  <= '0;
      r_value <= '0;
    end else if (i_clr) begin
      r_tens  <= '0;
      r_ones  <= '0;
      r_value <= '0;
    end else if (w_step) begin
      r_value <= r_value + SCORE_W'(1);
      if (r_ones == BCD_MAX) begin
        r_ones <= '0;
        r_tens <= r_tens + DIGIT_W'(1);
      end else begin
        r_ones <= r_ones + DIGIT_W'(1);
      end
    end
  end

  assign o_tens  = r_tens;
  assign o_ones  = r_ones;
  assign o_value = r_value;

endmodule

// File: rtl/score_ctrl.sv
// Game-score sequencer: frame-paced hold-repeat scoring in BCD, high-score
// tracking, freeze on collision and a timed digit flash before returning to idle.
//   i_clk, i_rst : pixel clock, async active-high reset
//   io (slave)   : frame tick / move / collision / restart in;
//                  score, digits, high score, state, digit enable out
module score_ctrl
  import crossy_pkg::*;
#(
  parameter int unsigned HOLD_FRAMES  = 8,
  parameter int unsigned MAX_SCORE    = 99,
  parameter int unsigned FLASH_FRAMES = 60,
  parameter int unsigned FLASH_PERIOD = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  score_ctrl_if.slave  io
);

  localparam int unsigned HOLD_W  = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam int unsigned FLASH_W = $clog2(FLASH_FRAMES + 1);

  state_t             r_state, w_state_nxt;
  logic [HOLD_W-1:0]  r_hold, w_hold_nxt;
  logic [FLASH_W-1:0] r_flash, w_flash_nxt;
  logic [SCORE_W-1:0] r_high, w_high_nxt;
  logic               r_digit_en, w_digit_en_nxt;

  logic [FLASH_W-1:0] w_flash_inc;
  logic               w_flash_odd;
  logic               w_clr;
  logic               w_inc;
  logic [SCORE_W-1:0] w_score;
  logic [DIGIT_W-1:0] w_tens;
  logic [DIGIT_W-1:0] w_ones;

  bcd2_counter u_score (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (w_clr),
    .i_inc   (w_inc),
    .i_limit (SCORE_W'(MAX_SCORE)),
    .o_tens  (w_tens),
    .o_ones  (w_ones),
    .o_value (w_score)
  );

  // Flash phase is judged on the count this tick produces, so the enable
  // register lines up with the counter value it belongs to.
  assign w_flash_inc = r_flash + FLASH_W'(1);
  assign w_flash_odd = 1'((32'(w_flash_inc) / FLASH_PERIOD) & 32'd1);

  // State and counter registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_hold     <= '0;
      r_flash    <= '0;
      r_high     <= '0;
      r_digit_en <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_hold     <= w_hold_nxt;
      r_flash    <= w_flash_nxt;
      r_high     <= w_high_nxt;
      r_digit_en <= w_digit_en_nxt;
    end
  end

  // Next-state and datapath control; restart outranks collision outranks tick.
  always_comb begin
    w_state_nxt    = r_state;
    w_hold_nxt     = r_hold;
    w_flash_nxt    = r_flash;
    w_high_nxt     = r_high;
    w_digit_en_nxt = r_digit_en;
    w_clr          = 1'b0;
    w_inc          = 1'b0;

    if (io.i_restart) begin
      w_state_nxt    = ST_PLAY;
      w_clr          = 1'b1;
      w_hold_nxt     = '0;
      w_flash_nxt    = '0;
      w_digit_en_nxt = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
        end
        ST_PLAY: begin
          if (io.i_collision) begin
            w_state_nxt    = ST_DEAD;
            w_flash_nxt    = '0;
            w_digit_en_nxt = 1'b1;
            if (w_score > r_high) begin
              w_high_nxt = w_score;
            end
          end else if (io.i_frame_tick) begin
            if (!io.i_move) begin
              w_hold_nxt = '0;
            end else if (r_hold != '0) begin
              w_hold_nxt = r_hold - HOLD_W'(1);
            end else begin
              // Counter drops the step itself once saturated.
              w_inc      = 1'b1;
              w_hold_nxt = HOLD_W'(HOLD_FRAMES - 1);
            end
          end
        end
        ST_DEAD: begin
          if (io.i_frame_tick) begin
            if (w_flash_inc == FLASH_W'(FLASH_FRAMES)) begin
              w_state_nxt    = ST_IDLE;
              w_flash_nxt    = '0;
              w_digit_en_nxt = 1'b1;
            end else begin
              w_flash_nxt    = w_flash_inc;
              w_digit_en_nxt = ~w_flash_odd;
            end
          end
        end
        default: begin
          w_state_nxt    = ST_IDLE;
          w_digit_en_nxt = 1'b1;
        end
      endcase
    end
  end

  assign io.o_score      = w_score;
  assign io.o_tens       = w_tens;
  assign io.o_ones       = w_ones;
  assign io.o_high_score = r_high;
  assign io.o_state      = r_state;
  assign io.o_digit_en   = r_digit_en;

endmodule

// File: tb/tb_score_ctrl.sv
module tb_score_ctrl;

  localparam int HOLD  = 8;
  localparam int MAXS  = 99;
  localparam int FLASH = 60;
  localparam int PER   = 8;

  logic clk;
  logic rst;

  score_ctrl_if bus ();

  score_ctrl #(
    .HOLD_FRAMES  (HOLD),
    .MAX_SCORE    (MAXS),
    .FLASH_FRAMES (FLASH),
    .FLASH_PERIOD (PER)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int score;
    int tens;
    int ones;
    int high;
    int state;
    int en;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: game rules as plain integer bookkeeping.
  int m_state, m_score, m_high, m_wait, m_flash, m_en;

  function automatic void model_reset();
    m_state = 0; m_score = 0; m_high = 0; m_wait = 0; m_flash = 0; m_en = 1;
  endfunction

  function automatic void model_step(input bit f, input bit mv, input bit col, input bit rs);
    if (rs) begin
      m_state = 1; m_score = 0; m_wait = 0; m_flash = 0; m_en = 1;
    end else if (m_state == 1) begin
      if (col) begin
        if (m_score > m_high) m_high = m_score;
        m_state = 2; m_flash = 0; m_en = 1;
      end else if (f) begin
        if (!mv) m_wait = 0;
        else if (m_wait > 0) m_wait = m_wait - 1;
        else begin
          if (m_score < MAXS) m_score = m_score + 1;
          m_wait = HOLD - 1;
        end
      end
    end else if (m_state == 2 && f) begin
      m_flash = m_flash + 1;
      if (m_flash == FLASH) begin
        m_state = 0; m_flash = 0; m_en = 1;
      end else begin
        m_en = ((m_flash / PER) % 2 == 0) ? 1 : 0;
      end
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.score = m_score;
    e.tens  = m_score / 10;
    e.ones  = m_score % 10;
    e.high  = m_high;
    e.state = m_state;
    e.en    = m_en;
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic compare(input exp_t e);
    chk("score", int'(bus.o_score), e.score);
    chk("tens",  int'(bus.o_tens), e.tens);
    chk("ones",  int'(bus.o_ones), e.ones);
    chk("high",  int'(bus.o_high_score), e.high);
    chk("state", int'(bus.o_state), e.state);
    chk("digit_en", int'(bus.o_digit_en), e.en);
  endtask

  // Monitor: every clock the DUT presents a new registered result.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) compare(q.pop_front());
    end
  end

  // Drive one cycle of inputs and queue the result expected after the edge.
  task automatic cyc(input bit f, input bit mv, input bit col, input bit rs);
    @(negedge clk);
    bus.i_frame_tick = f;
    bus.i_move       = mv;
    bus.i_collision  = col;
    bus.i_restart    = rs;
    model_step(f, mv, col, rs);
    q.push_back(model_out());
  endtask

  // One tap of the move button: an incrementing tick, then a released tick.
  task automatic press();
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
  endtask

  task automatic idle_inputs();
    @(negedge clk);
    bus.i_frame_tick = 0; bus.i_move = 0; bus.i_collision = 0; bus.i_restart = 0;
  endtask

  initial begin
    rst = 1'b1;
    bus.i_frame_tick = 0; bus.i_move = 0; bus.i_collision = 0; bus.i_restart = 0;
    model_reset();
    #12;
    compare(model_out());
    @(negedge clk);
    rst = 1'b0;

    // Build score 37 then hit reset between clock edges.
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 37; i++) press();
    idle_inputs();
    #2 rst = 1'b1;
    model_reset();
    #1 compare(model_out());
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Held move: 20 ticks spaced 4 cycles apart.
    cyc(0, 0, 0, 1);
    for (int t = 0; t < 20; t++) begin
      cyc(1, 1, 0, 0);
      for (int k = 0; k < 3; k++) cyc(0, 1, 0, 0);
    end
    cyc(1, 0, 0, 0);

    // Carry 09 -> 10, then saturate at 99.
    for (int i = 0; i < 7; i++) press();
    for (int i = 0; i < 95; i++) press();
    for (int t = 0; t < 10; t++) cyc(1, 1, 0, 0);
    for (int i = 0; i < 5; i++) press();

    // First game to 30, collide; second game to 42, collide on a frame tick.
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 30; i++) press();
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 42; i++) press();
    cyc(1, 1, 1, 0);
    for (int t = 0; t < 64; t++) begin
      cyc(1, 0, 0, 0);
      cyc(0, 0, (t == 5), 0);
    end

    // Restart mid-flash.
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) press();
    cyc(0, 0, 1, 0);
    for (int t = 0; t < 12; t++) cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);

    // Randomised play.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(2, 0) == 0,
          $urandom_range(3, 0) != 0,
          $urandom_range(199, 0) == 0,
          $urandom_range(149, 0) == 0);
    end

    idle_inputs();
    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
